// File: rtl/fp_multiply_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack, multiply, round/pack.
// Valid/ready backpressure stalls the whole pipe when the result is not taken.
module fp_multiply_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [2:0]             flags
);

    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W+MAN_W:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;

    // stage 1 registers
    logic                 s1_v_q, s1_sign_q, s1_rnd_q;
    logic                 s1_nan_q, s1_infz_q, s1_inf_q, s1_zero_q;
    logic [MW-1:0]        s1_ma_q, s1_mb_q;
    logic signed [EW-1:0] s1_esum_q;

    // stage 2 registers
    logic                 s2_v_q, s2_sign_q, s2_rnd_q;
    logic                 s2_nan_q, s2_infz_q, s2_inf_q, s2_zero_q;
    logic [PW-1:0]        s2_prod_q;
    logic signed [EW-1:0] s2_esum_q;

    // output registers
    logic                 out_valid_q;
    logic [EXP_W+MAN_W:0] out_q, out_d;
    logic [2:0]           flags_q, flags_d;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;

    // unpack / classify
    logic [EXP_W-1:0]     ea, eb;
    logic                 za, zb, ia, ib, na, nb;
    logic signed [EW-1:0] esum_d;

    assign ea = a[MAN_W +: EXP_W];
    assign eb = b[MAN_W +: EXP_W];
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (&ea) && (a[MAN_W-1:0] == '0);
    assign ib = (&eb) && (b[MAN_W-1:0] == '0);
    assign na = (&ea) && (a[MAN_W-1:0] != '0);
    assign nb = (&eb) && (b[MAN_W-1:0] != '0);
    assign esum_d = EW'(ea) + EW'(eb) - EW'(BIAS);

    // normalise / round
    logic [PW-1:0]        norm;
    logic                 guard, sticky, inc;
    logic [MW:0]          mant_r;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_r;
    logic                 ovf, unf;

    assign norm   = s2_prod_q[PW-1] ? s2_prod_q
                                    : {s2_prod_q[PW-2:0], 1'b0};
    assign guard  = norm[MW-1];
    assign sticky = |norm[MW-2:0];
    assign inc    = !s2_rnd_q && guard && (sticky || norm[PW-MW]);
    assign mant_r = {1'b0, norm[PW-1 -: MW]} + {{MW{1'b0}}, inc};
    assign frac   = mant_r[MW] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign e_r    = s2_esum_q
                  + $signed({{(EW-1){1'b0}}, s2_prod_q[PW-1]})
                  + $signed({{(EW-1){1'b0}}, mant_r[MW]});
    assign ovf    = (e_r >= EMAX);
    assign unf    = e_r[EW-1] || (e_r == '0);

    always_comb begin
        out_d   = {s2_sign_q, e_r[EXP_W-1:0], frac};
        flags_d = 3'b000;
        if (s2_nan_q) begin
            out_d = QNAN;
        end else if (s2_infz_q) begin
            out_d   = QNAN;
            flags_d = 3'b100;
        end else if (s2_inf_q) begin
            out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero_q) begin
            out_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else if (ovf) begin
            flags_d = 3'b010;
            if (s2_rnd_q)
                out_d = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else
                out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            out_d   = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d = 3'b001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_infz_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_esum_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rnd_q    <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_infz_q   <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_prod_q   <= '0;
            s2_esum_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= 3'b000;
        end else if (advance) begin
            s1_v_q      <= in_valid;
            s1_sign_q   <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
            s1_rnd_q    <= rnd_mode;
            s1_nan_q    <= na || nb;
            s1_infz_q   <= (ia && zb) || (ib && za);
            s1_inf_q    <= ia || ib;
            s1_zero_q   <= za || zb;
            s1_ma_q     <= {1'b1, a[MAN_W-1:0]};
            s1_mb_q     <= {1'b1, b[MAN_W-1:0]};
            s1_esum_q   <= esum_d;
            s2_v_q      <= s1_v_q;
            s2_sign_q   <= s1_sign_q;
            s2_rnd_q    <= s1_rnd_q;
            s2_nan_q    <= s1_nan_q;
            s2_infz_q   <= s1_infz_q;
            s2_inf_q    <= s1_inf_q;
            s2_zero_q   <= s1_zero_q;
            s2_prod_q   <= PW'(s1_ma_q) * PW'(s1_mb_q);
            s2_esum_q   <= s1_esum_q;
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_q   <= out_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule
